// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop sync, per-bit debounce, press/release pulses.
// Optional auto-repeat on held buttons when BTN_REPEAT_EN is defined.
`timescale 1ns/1ps
module btn_debounce #(
  parameter int unsigned N_BTN        = 4,
  parameter int unsigned CNT_W        = 20,
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter int unsigned HOLD_CYC     = 50000000,
  parameter int unsigned REPEAT_CYC   = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_i,
  output logic [N_BTN-1:0] btn_o,
  output logic [N_BTN-1:0] btn_lvl_o,
  output logic [N_BTN-1:0] btn_rel_o
);

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;
  logic [N_BTN-1:0] r_stable;
  logic [N_BTN-1:0] r_press;
  logic [N_BTN-1:0] r_rel;
  logic [CNT_W-1:0] r_cnt [N_BTN];

  logic [N_BTN-1:0] w_stable_nxt;
  logic [N_BTN-1:0] w_press_nxt;
  logic [N_BTN-1:0] w_rel_nxt;
  logic [N_BTN-1:0] w_accept;
  logic [N_BTN-1:0] w_rpt;
  logic [CNT_W-1:0] w_cnt_nxt [N_BTN];

  // Debounce: count cycles of disagreement, accept after DEBOUNCE_CYC of them.
  always_comb begin
    w_stable_nxt = r_stable;
    w_cnt_nxt    = r_cnt;
    w_press_nxt  = '0;
    w_rel_nxt    = '0;
    w_accept     = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      if (r_sync2[i] == r_stable[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (r_cnt[i] == CNT_W'(DEBOUNCE_CYC - 1)) begin
        w_accept[i]     = 1'b1;
        w_stable_nxt[i] = r_sync2[i];
        w_cnt_nxt[i]    = '0;
        w_press_nxt[i]  = r_sync2[i];
        w_rel_nxt[i]    = ~r_sync2[i];
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      r_press  <= '0;
      r_rel    <= '0;
      r_cnt    <= '{default: '0};
    end else begin
      r_sync1  <= btn_i;
      r_sync2  <= r_sync1;
      r_stable <= w_stable_nxt;
      r_press  <= w_press_nxt | w_rpt;
      r_rel    <= w_rel_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

`ifdef BTN_REPEAT_EN
  localparam int unsigned HOLD_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

  logic [HOLD_W-1:0] r_hold [N_BTN];
  logic [HOLD_W-1:0] w_hold_nxt [N_BTN];
  logic [N_BTN-1:0]  r_rep;
  logic [N_BTN-1:0]  w_rep_nxt;

  // Hold timer: first repeat after HOLD_CYC, then every REPEAT_CYC while held.
  always_comb begin
    w_hold_nxt = r_hold;
    w_rep_nxt  = r_rep;
    w_rpt      = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      if (!r_stable[i] || w_accept[i]) begin
        w_hold_nxt[i] = '0;
        w_rep_nxt[i]  = 1'b0;
      end else if (r_hold[i] == (r_rep[i] ? HOLD_W'(REPEAT_CYC - 1) : HOLD_W'(HOLD_CYC - 1))) begin
        w_rpt[i]      = 1'b1;
        w_hold_nxt[i] = '0;
        w_rep_nxt[i]  = 1'b1;
      end else begin
        w_hold_nxt[i] = r_hold[i] + HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold <= '{default: '0};
      r_rep  <= '0;
    end else begin
      r_hold <= w_hold_nxt;
      r_rep  <= w_rep_nxt;
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{32'(HOLD_CYC), 32'(REPEAT_CYC), w_accept};
  assign w_rpt        = '0;
`endif

  assign btn_o     = r_press;
  assign btn_lvl_o = r_stable;
  assign btn_rel_o = r_rel;

endmodule
